// File: rtl/trace_pkg.sv
// Shared types for the execution trace capture block: FSM state encoding,
// the captured sample record, and a few width helpers.
package trace_pkg;

    // Capture session states; values are visible on state_o
    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_ARMED   = 2'd1;
    localparam logic [1:0] ENC_CAPTURE = 2'd2;
    localparam logic [1:0] ENC_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ENC_IDLE,
        ST_ARMED   = ENC_ARMED,
        ST_CAPTURE = ENC_CAPTURE,
        ST_DONE    = ENC_DONE
    } trace_state_t;

    // Field widths of one trace record
    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int FLAG_W = 8;

    // One recorded processor sample (72 bits)
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [FLAG_W-1:0] flag;
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

    // Sample counter width; holds CAP_LEN up to 255
    localparam int SCNT_W = 8;

    // Occupancy counter width for a FIFO of the given depth (0..depth inclusive)
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular buffer of trace records. Pointers wrap naturally at DEPTH (power
// of two). A pop on an empty buffer is ignored; a push on a full buffer is
// accepted only when a pop frees a slot in the same cycle. flush empties the
// buffer synchronously and wins over push and pop.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  trace_entry_t                   din,
    input  logic                           pop,
    output trace_entry_t                   dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    trace_entry_t  mem [DEPTH];
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is read straight from storage so out fields follow rptr immediately
    assign dout = mem[rptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wptr] <= din;
    end

endmodule

// File: rtl/exec_trace_capture.sv
// Execution trace capture: records processor PC / instruction / ALU flag
// samples into a FIFO, either immediately on arm or starting from the first
// sample whose PC matches trig_pc, for CAP_LEN samples. Samples that find the
// FIFO full are dropped but still consume the capture budget, and raise a
// sticky overflow flag. The FIFO can be drained in any state.
module exec_trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CAP_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      clear,
    input  logic                      trig_en,
    input  logic [31:0]               trig_pc,
    input  logic                      smp_valid,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               inst_in,
    input  logic [7:0]                flag_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_inst,
    output logic [7:0]                out_flag,
    output logic [1:0]                state_o,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam logic [SCNT_W-1:0] CAP_LAST = SCNT_W'(CAP_LEN);

    logic [1:0]        rst_sync;
    logic              rst_i;
    trace_state_t      state;
    logic [SCNT_W-1:0] smp_cnt;
    logic [SCNT_W-1:0] cnt_next;
    logic              pc_hit;
    logic              rec;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    trace_entry_t      smp;
    trace_entry_t      head;

    // Reset asserts immediately and releases two edges later, aligned to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    assign pc_hit = smp_valid && (pc_in == trig_pc);
    assign smp    = '{pc: pc_in, inst: inst_in, flag: flag_in};

    // Decide whether this cycle's sample is part of the capture; clear vetoes it
    always_comb begin
        rec = 1'b0;
        if (!clear) begin
            case (state)
                ST_ARMED:   rec = pc_hit;
                ST_CAPTURE: rec = smp_valid;
                default:    rec = 1'b0;
            endcase
        end
    end

    // The trigger sample is entry 1; later samples extend the running count
    assign cnt_next = (state == ST_ARMED) ? SCNT_W'(1) : smp_cnt + 1'b1;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !clear;
    assign drop      = rec && full && !pop;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_i),
        .flush (clear),
        .push  (rec),
        .din   (smp),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_pc   = head.pc;
    assign out_inst = head.inst;
    assign out_flag = head.flag;
    assign state_o  = state;

    // Session FSM, sample counter and sticky overflow
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            smp_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            smp_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state   <= trig_en ? ST_ARMED : ST_CAPTURE;
                        smp_cnt <= '0;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (rec) begin
                        smp_cnt <= cnt_next;
                        state   <= (cnt_next == CAP_LAST) ? ST_DONE : ST_CAPTURE;
                    end
                end
                default: state <= ST_DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_trace_capture.sv
// Bench for exec_trace_capture. Two instances share all inputs: one with the
// default CAP_LEN=8 and one with CAP_LEN=20, both DEPTH=16. A reference model
// of the capture rules runs alongside and every output is compared each cycle.
module tb_exec_trace_capture;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int NI    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0, clear = 1'b0, trig_en = 1'b0, smp_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] trig_pc = 32'h0, pc_in = 32'h0, inst_in = 32'h0;
    logic [7:0]  flag_in = 8'h0;

    logic        ov  [NI];
    logic [31:0] opc [NI];
    logic [31:0] oin [NI];
    logic [7:0]  ofl [NI];
    logic [1:0]  st  [NI];
    logic [4:0]  cnt [NI];
    logic        ovf [NI];

    int checks = 0;
    int errors = 0;

    // Reference model: plain circular store, session state as spec encodings
    int           cap   [NI] = '{8, 20};
    int           mst   [NI];
    int           mn    [NI];
    int           mhead [NI];
    int           msize [NI];
    int           movf  [NI];
    trace_entry_t mmem  [NI][DEPTH];

    always #5 clk = ~clk;

    exec_trace_capture #(.DEPTH(DEPTH), .CAP_LEN(8)) dut0 (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc),
        .smp_valid(smp_valid), .pc_in(pc_in), .inst_in(inst_in), .flag_in(flag_in),
        .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]), .out_inst(oin[0]),
        .out_flag(ofl[0]), .state_o(st[0]), .count(cnt[0]), .overflow(ovf[0])
    );

    exec_trace_capture #(.DEPTH(DEPTH), .CAP_LEN(20)) dut1 (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc),
        .smp_valid(smp_valid), .pc_in(pc_in), .inst_in(inst_in), .flag_in(flag_in),
        .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]), .out_inst(oin[1]),
        .out_flag(ofl[1]), .state_o(st[1]), .count(cnt[1]), .overflow(ovf[1])
    );

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mst[i] = 0; mn[i] = 0; mhead[i] = 0; msize[i] = 0; movf[i] = 0;
        end
    endtask

    // Apply one clock of the capture rules to the model using current inputs
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit popq, recq;
            popq = (msize[i] > 0) && out_ready;
            recq = 1'b0;
            if (clear) begin
                mst[i] = 0; mn[i] = 0; msize[i] = 0; movf[i] = 0;
            end else begin
                if (mst[i] == 0 && arm) begin
                    mst[i] = trig_en ? 1 : 2;
                    mn[i]  = 0;
                end else if (mst[i] == 1 && smp_valid && pc_in == trig_pc) begin
                    recq = 1'b1; mn[i] = 1;
                    mst[i] = (mn[i] == cap[i]) ? 3 : 2;
                end else if (mst[i] == 2 && smp_valid) begin
                    recq = 1'b1; mn[i] = mn[i] + 1;
                    if (mn[i] == cap[i]) mst[i] = 3;
                end
                if (popq) begin
                    mhead[i] = (mhead[i] + 1) % DEPTH;
                    msize[i] = msize[i] - 1;
                end
                if (recq) begin
                    if (msize[i] < DEPTH) begin
                        mmem[i][(mhead[i] + msize[i]) % DEPTH] = '{pc: pc_in, inst: inst_in, flag: flag_in};
                        msize[i] = msize[i] + 1;
                    end else begin
                        movf[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("state", i, 32'(st[i]), 32'(mst[i]));
            chk("count", i, 32'(cnt[i]), 32'(msize[i]));
            chk("overflow", i, 32'(ovf[i]), 32'(movf[i]));
            chk("out_valid", i, 32'(ov[i]), 32'(msize[i] > 0));
            if (msize[i] > 0) begin
                chk("out_pc", i, opc[i], mmem[i][mhead[i]].pc);
                chk("out_inst", i, oin[i], mmem[i][mhead[i]].inst);
                chk("out_flag", i, 32'(ofl[i]), 32'(mmem[i][mhead[i]].flag));
            end
        end
    endtask

    // Inputs are set at a falling edge; advance one cycle and compare
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
        arm   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic sample(input logic [31:0] pc);
        smp_valid = 1'b1;
        pc_in     = pc;
        inst_in   = $urandom;
        flag_in   = 8'($urandom);
        step();
        smp_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
    endtask

    task automatic do_arm(input logic te);
        trig_en = te;
        arm     = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        // Reset state
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_state", i, 32'(st[i]), 32'(ENC_IDLE));
            chk("rst_count", i, 32'(cnt[i]), 32'd0);
            chk("rst_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_ovf", i, 32'(ovf[i]), 32'd0);
        end
        rst = 1'b1;
        repeat (3) step();

        // Triggered capture: PC stream 0x0..0x2C, trigger at 0x10
        trig_pc = 32'h10;
        do_arm(1'b1);
        chk("armed", 0, 32'(st[0]), 32'(ENC_ARMED));
        for (int k = 0; k < 12; k++) sample(32'(4 * k));
        chk("trig_done", 0, 32'(st[0]), 32'(ENC_DONE));
        chk("trig_count", 0, 32'(cnt[0]), 32'd8);
        chk("trig_ovf", 0, 32'(ovf[0]), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_pc", 0, opc[0], 32'h10 + 32'(4 * k));
            step();
        end
        out_ready = 1'b0;
        chk("drained", 0, 32'(cnt[0]), 32'd0);

        // Immediate capture with no draining: overflow in the deep-capture instance
        do_clear();
        do_arm(1'b0);
        for (int k = 0; k < 20; k++) begin
            sample($urandom);
            if (k < 19) chk("ovf_not_done", 1, 32'(st[1]), 32'(ENC_CAPTURE));
        end
        chk("ovf_done", 1, 32'(st[1]), 32'(ENC_DONE));
        chk("ovf_count", 1, 32'(cnt[1]), 32'd16);
        chk("ovf_flag", 1, 32'(ovf[1]), 32'd1);
        do_arm(1'b0);
        chk("arm_ignored_done", 1, 32'(st[1]), 32'(ENC_DONE));

        // Full FIFO with simultaneous push and pop
        do_clear();
        do_arm(1'b0);
        for (int k = 0; k < 16; k++) sample($urandom);
        chk("full_count", 1, 32'(cnt[1]), 32'd16);
        out_ready = 1'b1;
        sample(32'hABC0);
        out_ready = 1'b0;
        chk("pushpop_count", 1, 32'(cnt[1]), 32'd16);
        chk("pushpop_ovf", 1, 32'(ovf[1]), 32'd0);

        // Continuous draining: each entry popped the cycle after its write
        do_clear();
        out_ready = 1'b1;
        do_arm(1'b0);
        for (int k = 0; k < 10; k++) begin
            sample(32'h100 + 32'(4 * k));
            chk("stream_count", 1, 32'(cnt[1]), 32'd1);
            chk("stream_pc", 1, opc[1], 32'h100 + 32'(4 * k));
        end
        step();
        chk("stream_empty", 1, 32'(cnt[1]), 32'd0);
        out_ready = 1'b0;

        // clear beats arm and a matching sample in the same cycle
        do_clear();
        clear = 1'b1; arm = 1'b1; trig_en = 1'b1;
        sample(trig_pc);
        for (int i = 0; i < NI; i++) begin
            chk("clr_arm_state", i, 32'(st[i]), 32'(ENC_IDLE));
            chk("clr_arm_count", i, 32'(cnt[i]), 32'd0);
        end

        // Randomized sessions
        for (int n = 0; n < 600; n++) begin
            arm       = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            trig_en   = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            smp_valid = ($urandom_range(0, 9) < 7);
            pc_in     = ($urandom_range(0, 3) == 0) ? trig_pc : 32'($urandom_range(0, 15) * 4);
            inst_in   = $urandom;
            flag_in   = 8'($urandom);
            step();
        end
        smp_valid = 1'b0;
        out_ready = 1'b0;

        // Asynchronous reset mid-capture with 5 entries held
        do_clear();
        do_arm(1'b0);
        for (int k = 0; k < 5; k++) sample($urandom);
        chk("pre_rst_count", 1, 32'(cnt[1]), 32'd5);
        #2 rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            chk("arst_state", i, 32'(st[i]), 32'(ENC_IDLE));
            chk("arst_count", i, 32'(cnt[i]), 32'd0);
            chk("arst_valid", i, 32'(ov[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        do_arm(1'b0);
        sample(32'h55);
        chk("post_rst_count", 1, 32'(cnt[1]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case the stimulus ever stalls
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_trace_capture.md
EXEC_TRACE_CAPTURE -- requirements
Module: exec_trace_capture

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..64.
REQ-002 Parameter CAP_LEN, default 8, samples recorded per trigger; 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-low, synchronous deassert.
REQ-005 arm  input  1  one-cycle pulse; starts a capture session.
REQ-006 clear  input  1  one-cycle pulse; aborts the session, flushes the FIFO, clears status.
REQ-007 trig_en  input  1  1 = wait for PC match; 0 = capture immediately.
REQ-008 trig_pc  input  32  PC value that fires the trigger.
REQ-009 smp_valid  input  1  qualifies the sample inputs this cycle.
REQ-010 pc_in  input  32  processor PC_Out.
REQ-011 inst_in  input  32  processor Imemo_Inst.
REQ-012 flag_in  input  8  processor ALU_Flag.
REQ-013 out_valid  output  1  head entry available.
REQ-014 out_ready  input  1  consumer accepts the head entry.
REQ-015 out_pc, out_inst, out_flag  output  32/32/8  head entry fields.
REQ-016 state_o  output  2  encoding IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-017 count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-018 overflow  output  1  sticky flag; a sample was dropped because the FIFO was full.

Function
REQ-019 The FSM SHALL have four states:
- IDLE -> ARMED on arm with trig_en=1.
- IDLE -> CAPTURE on arm with trig_en=0.
REQ-020 In ARMED, a cycle with smp_valid=1 and pc_in==trig_pc SHALL move the FSM to CAPTURE and SHALL record that sample as entry 1.
REQ-021 In CAPTURE, every smp_valid=1 cycle SHALL record one sample; when the CAP_LEN-th sample is recorded the FSM SHALL go to DONE on the same edge.
REQ-022 CAP_LEN=1 with a trigger SHALL go ARMED -> DONE directly, writing one entry.
REQ-023 A sample arriving while the FIFO is full (and not popped that cycle) SHALL be dropped, SHALL set overflow, and SHALL still count toward CAP_LEN.
REQ-024 Push and pop in the same cycle on a full FIFO SHALL both succeed; count stays DEPTH.
REQ-025 Push and pop in the same cycle on an empty FIFO: the pop is ignored and the push is accepted.
REQ-026 A written entry SHALL appear on out_valid on the next cycle (1-cycle latency); the out_* fields SHALL reflect the head combinationally from storage.
REQ-027 A pop SHALL occur exactly when out_valid && out_ready; draining SHALL be allowed in every state.
REQ-028 arm SHALL be ignored in ARMED, CAPTURE and DONE.
REQ-029 DONE SHALL hold until clear.
REQ-030 clear SHALL take priority over arm and over any sample in the same cycle:
- next state IDLE
- count 0
- overflow 0
- sample counter 0
REQ-031 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.

Reset
REQ-032 While rst=0: state IDLE, pointers 0, count 0, overflow 0, sample counter 0, out_valid 0.
REQ-033 Asserting reset mid-capture SHALL abandon the session; entry contents need not be cleared.

Structure
REQ-034 Package trace_pkg SHALL hold:
- the state enum trace_state_t
- the struct trace_entry_t {pc 32, inst 32, flag 8} (72 bits)
- the encoding constants
REQ-035 The storage and pointer logic SHALL be a separate sub-module trace_fifo (DEPTH-parameterised, trace_entry_t width, push/pop/full/empty/count).
REQ-036 The FSM and sample counter SHALL reside in exec_trace_capture.

Verification
REQ-037 trig_en=1, trig_pc=0x10; PC stream 0x0,0x4,...,0x2C with smp_valid=1 -> ARMED until 0x10; then 8 entries PCs 0x10..0x2C, DONE, count=8, overflow=0.
REQ-038 trig_en=0, arm, 20 valid samples, out_ready=0, DEPTH=16, CAP_LEN=20 -> count=16, overflow=1, DONE after the 20th sample.
REQ-039 Capture running with out_ready=1 held -> each entry popped one cycle after its write; count toggles between 0 and 1; order preserved.
REQ-040 FIFO full, pop and push in the same cycle -> count stays 16; the new entry becomes the tail; overflow unchanged.
REQ-041 clear asserted in the same cycle as arm and a matching sample -> IDLE, count=0, no entry written.
REQ-042 rst low for 1 cycle mid-CAPTURE with 5 entries -> IDLE, count=0, out_valid=0 immediately (asynchronous).
